// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for eight requesters with an 8:1 data mux.
// The winner holds the grant for up to MAX_HOLD cycles, the mux output is
// captured every GRANT cycle, and each handover passes through exactly one
// RELEASE cycle with no grant asserted.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4   // legal range 1..15 (cnt is 4 bits wide)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       out,
    output logic       out_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [3:0] cnt_q;
    logic [7:0] gnt_q;
    logic [2:0] sel_q;
    logic       busy_q;
    logic       out_q;
    logic       out_valid_q;

    // Request vector rotated so that bit 0 is the requester at ptr_q.
    logic [7:0] req_rot;
    logic [2:0] win_off;
    logic [2:0] winner;
    logic [7:0] winner_onehot;
    logic       keep_grant;

    // Rotation by the pointer; 3-bit index arithmetic gives the mod-8 wrap.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_q + 3'(gi)];
    end

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        win_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 3'(k);
            end
        end
    end

    assign winner        = ptr_q + win_off;
    assign winner_onehot = 8'b1 << winner;

    // Owner keeps the grant while it still requests and has tenure left.
    assign keep_grant = req[sel_q] && (cnt_q < HOLD_LIMIT);

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            cnt_q       <= 4'd0;
            gnt_q       <= 8'd0;
            sel_q       <= 3'd0;
            busy_q      <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and RELEASE arbitrate identically; ptr is never touched here.
                IDLE, RELEASE: begin
                    out_valid_q <= 1'b0;
                    if (|req) begin
                        state_q <= GRANT;
                        gnt_q   <= winner_onehot;
                        sel_q   <= winner;
                        cnt_q   <= 4'd1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    // Capture happens on every GRANT edge, the exit edge included.
                    out_q       <= in[sel_q];
                    out_valid_q <= 1'b1;
                    if (keep_grant) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        // sel holds the last owner; priority moves just past it.
                        state_q <= RELEASE;
                        gnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                        ptr_q   <= sel_q + 3'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= 8'd0;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: two instances (MAX_HOLD=4 and
// MAX_HOLD=1). Stimulus pushes expected tenures and captured data bits;
// one monitor per instance pops and compares as the DUT presents them.
module tb_mux_rr_arbiter;

    typedef struct {
        int owner;
        int tenure;
        int gap;      // required gnt=0 samples before this grant, -1 = unchecked
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_w [2];
    logic [7:0] in_v;
    logic [7:0] gnt_w [2];
    logic [2:0] sel_w [2];
    logic       busy_w [2];
    logic       out_w [2];
    logic       ov_w [2];

    exp_t exp_q [2][$];
    bit   out_exp_q [2][$];

    int tests = 0;
    int fails = 0;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_w[0]), .in(in_v),
        .gnt(gnt_w[0]), .sel(sel_w[0]), .busy(busy_w[0]),
        .out(out_w[0]), .out_valid(ov_w[0])
    );

    mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_w[1]), .in(in_v),
        .gnt(gnt_w[1]), .sel(sel_w[1]), .busy(busy_w[1]),
        .out(out_w[1]), .out_valid(ov_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req_val);
        tests++;
        if (act != req_val) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req_val, $time);
        end
    endtask

    // Push one expected tenure plus its captured data bit per out_valid pulse.
    task automatic push_ten(input int inst, input int owner, input int tenure,
                            input int gap, input bit outbit);
        exp_t e;
        e.owner  = owner;
        e.tenure = tenure;
        e.gap    = gap;
        exp_q[inst].push_back(e);
        for (int k = 0; k < tenure; k++) out_exp_q[inst].push_back(outbit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_w[0] = 8'h00;
        req_w[1] = 8'h00;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitors: one per instance, sampling on the falling edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        exp_t       cur;
        int         ten, ov, bc, gap;
        logic [7:0] prev;
        always @(negedge clk) begin
            if (!rst_n) begin
                prev = 8'h00; ten = 0; ov = 0; bc = 0; gap = 99;
                cur.owner = 0; cur.tenure = 0; cur.gap = -1;
            end else begin
                if (ov_w[gi]) begin
                    if (out_exp_q[gi].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL out_extra%0d: got out_valid=1 out=%0d, required no pulse", gi, out_w[gi]);
                    end else begin
                        chk($sformatf("out%0d", gi), int'(out_w[gi]), int'(out_exp_q[gi].pop_front()));
                    end
                    ov++;
                end
                if (gnt_w[gi] != 8'h00 && prev == 8'h00) begin
                    if (exp_q[gi].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL grant_extra%0d: got gnt=%h, required no grant", gi, gnt_w[gi]);
                        cur.owner = int'(sel_w[gi]); cur.tenure = 0; cur.gap = -1;
                    end else begin
                        cur = exp_q[gi].pop_front();
                        chk($sformatf("gnt%0d", gi), int'(gnt_w[gi]), 1 << cur.owner);
                        chk($sformatf("sel%0d", gi), int'(sel_w[gi]), cur.owner);
                        if (cur.gap >= 0) chk($sformatf("gap%0d", gi), gap, cur.gap);
                    end
                    ten = 1;
                    ov  = 0;
                    bc  = busy_w[gi] ? 1 : 0;
                end else if (gnt_w[gi] != 8'h00) begin
                    chk($sformatf("gnt_hold%0d", gi), int'(gnt_w[gi]), 1 << cur.owner);
                    ten++;
                    if (busy_w[gi]) bc++;
                end else if (prev != 8'h00) begin
                    chk($sformatf("tenure%0d", gi), ten, cur.tenure);
                    chk($sformatf("pulses%0d", gi), ov, cur.tenure);
                    chk($sformatf("busy_cycles%0d", gi), bc, cur.tenure);
                    chk($sformatf("busy_rel%0d", gi), int'(busy_w[gi]), 0);
                    chk($sformatf("sel_rel%0d", gi), int'(sel_w[gi]), cur.owner);
                    gap = 1;
                end else begin
                    gap++;
                end
                prev = gnt_w[gi];
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        req_w[0] = 8'h00;
        req_w[1] = 8'h00;
        in_v     = 8'h00;
        #12;
        // Reset state (async, no clock edge required).
        chk("rst_gnt", int'(gnt_w[0]), 0);
        chk("rst_sel", int'(sel_w[0]), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_out", int'(out_w[0]), 0);
        chk("rst_ov", int'(ov_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester 2 held: tenure of 4, one gap, re-grant to 2.
        $display("[TB] txn: req=04 held, in=00");
        push_ten(0, 2, 4, -1, 1'b0);
        push_ten(0, 2, 4, 1, 1'b0);
        req_w[0] = 8'h04;
        repeat (10) @(negedge clk);
        req_w[0] = 8'h00;
        repeat (3) @(negedge clk);

        // All requesting: order 0..7 then 0, data from in=55.
        do_reset();
        $display("[TB] txn: req=FF held, in=55");
        in_v = 8'h55;
        for (int k = 0; k < 9; k++)
            push_ten(0, k % 8, 4, (k == 0) ? -1 : 1, ((k % 8) % 2) == 0);
        req_w[0] = 8'hFF;
        repeat (45) @(negedge clk);
        req_w[0] = 8'h00;
        repeat (3) @(negedge clk);

        // Owner 5 drops after 2 cycles; req[1] then wins via wrapped ptr.
        do_reset();
        $display("[TB] txn: owner 5 early drop, req[1] pending, in=02");
        in_v = 8'h02;
        push_ten(0, 5, 2, -1, 1'b0);
        push_ten(0, 1, 4, 1, 1'b1);
        req_w[0] = 8'h20;
        @(negedge clk);
        req_w[0] = 8'h22;
        @(negedge clk);
        req_w[0] = 8'h02;
        repeat (6) @(negedge clk);
        req_w[0] = 8'h00;
        repeat (3) @(negedge clk);

        // Owner 7 data capture; in[7] drops mid-tenure.
        do_reset();
        $display("[TB] txn: owner 7, in=A0 then in[7]=0");
        in_v = 8'hA0;
        exp_q[0].push_back('{owner: 7, tenure: 4, gap: -1});
        out_exp_q[0].push_back(1'b1);
        out_exp_q[0].push_back(1'b0);
        out_exp_q[0].push_back(1'b0);
        out_exp_q[0].push_back(1'b0);
        req_w[0] = 8'h80;
        repeat (2) @(negedge clk);
        in_v = 8'h20;
        repeat (3) @(negedge clk);
        req_w[0] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset mid-GRANT to owner 3, then restart from ptr=0.
        do_reset();
        $display("[TB] txn: reset during grant to 3, then req=09");
        in_v = 8'h00;
        exp_q[0].push_back('{owner: 3, tenure: 4, gap: -1});
        out_exp_q[0].push_back(1'b0);
        req_w[0] = 8'h08;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_gnt", int'(gnt_w[0]), 0);
        chk("midrst_busy", int'(busy_w[0]), 0);
        chk("midrst_ov", int'(ov_w[0]), 0);
        chk("midrst_sel", int'(sel_w[0]), 0);
        push_ten(0, 0, 4, -1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        req_w[0] = 8'h09;
        repeat (5) @(posedge clk);
        @(negedge clk);
        req_w[0] = 8'h00;
        repeat (3) @(negedge clk);

        // MAX_HOLD=1 instance: 0 and 7 alternate, one cycle each.
        $display("[TB] txn: MAX_HOLD=1, req=81 held, in=80");
        in_v = 8'h80;
        push_ten(1, 0, 1, -1, 1'b0);
        push_ten(1, 7, 1, 1, 1'b1);
        push_ten(1, 0, 1, 1, 1'b0);
        push_ten(1, 7, 1, 1, 1'b1);
        req_w[1] = 8'h81;
        repeat (8) @(negedge clk);
        req_w[1] = 8'h00;
        repeat (3) @(negedge clk);

        // Every expected grant and capture must have been consumed.
        chk("left_grants0", exp_q[0].size(), 0);
        chk("left_outs0", out_exp_q[0].size(), 0);
        chk("left_grants1", exp_q[1].size(), 0);
        chk("left_outs1", out_exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
